// File: rtl/psk_mod.sv
// -----------------------------------------------------------------------------
// psk_mod -- M-PSK (BPSK / QPSK) baseband modulator
//
// A serial bit stream arrives over a valid/ready handshake and is packed into
// 1-bit (BPSK) or 2-bit (QPSK, Gray coded) symbols. Each symbol is played out
// as CYCLES_PER_SYM periods of an offset-binary sine carrier whose phase is
// shifted by the symbol value. The carrier comes from a quarter-wave table
// (LUT_SIZE/4+1 entries) unfolded by symmetry. Symbols follow each other
// without a gap as long as the next one is complete by the last sample of the
// current one; otherwise an underrun pulse is raised and the output returns
// to midscale.
//
// Optional feature (compile-time macro):
//   PSK_DIFF_EN  defined   -> differential phase: the applied phase is a
//                             running sum of symbol offsets (mod LUT_SIZE),
//                             cleared by rst and on underrun.
//                undefined -> absolute phase, symbol offset used directly.
//
// Parameters:
//   WIDTH          sample width in bits (4..12)
//   LUT_SIZE       samples per carrier period (power of two, >= 8)
//   CYCLES_PER_SYM carrier periods per symbol (>= 1)
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset (wins over en)
//   en           in   clock enable; 0 holds all state and outputs
//   mode         in   0 = BPSK, 1 = QPSK (latched on first bit of a symbol)
//   bit_in       in   serial data bit, first accepted bit is the MSB
//   bit_valid    in   bit_in is valid
//   bit_ready    out  bit_in is accepted this cycle (combinational)
//   sample_out   out  registered offset-binary carrier sample
//   sample_valid out  sample_out carries a modulated sample
//   sym_start    out  pulse on the first sample of each symbol
//   underrun     out  pulse on the last sample when no next symbol is ready
// -----------------------------------------------------------------------------
module psk_mod #(
  parameter int WIDTH          = 8,
  parameter int LUT_SIZE       = 64,
  parameter int CYCLES_PER_SYM = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             sym_start,
  output logic             underrun
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int KW  = $clog2(LUT_SIZE);
  localparam int PW  = (CYCLES_PER_SYM > 1) ? $clog2(CYCLES_PER_SYM) : 1;
  localparam int QN  = LUT_SIZE / 4;
  localparam int AMP = (1 << (WIDTH - 1)) - 1;

  localparam logic [WIDTH-1:0] MID      = WIDTH'(1 << (WIDTH - 1));
  localparam logic [KW-1:0]    K_LAST   = KW'(LUT_SIZE - 1);
  localparam logic [PW-1:0]    P_LAST   = PW'(CYCLES_PER_SYM - 1);
  localparam logic [KW-1:0]    OFF_Q1   = KW'(QN);
  localparam logic [KW-1:0]    OFF_Q2   = KW'(2 * QN);
  localparam logic [KW-1:0]    OFF_Q3   = KW'(3 * QN);
  localparam logic [KW-2:0]    QN_IDX   = (KW-1)'(QN);

  localparam real PI = 3.14159265358979323846;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Quarter-wave sine table, magnitudes only, computed at elaboration.
  // Entry j = round(AMP * sin(2*pi*j/LUT_SIZE)), j = 0..LUT_SIZE/4.
  // ---------------------------------------------------------------------------
  logic [WIDTH-2:0] qtab_s [0:QN];

  for (genvar j = 0; j <= QN; j++) begin : g_qtab
    localparam real ANG = 2.0 * PI * j / LUT_SIZE;
    localparam int  QV  = $rtoi(AMP * $sin(ANG) + 0.5);
    assign qtab_s[j] = (WIDTH-1)'(QV);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           state_r;
  state_t           state_nx_s;

  logic [1:0]       col_r;        // collector shift register, LSB = newest bit
  logic [1:0]       col_cnt_r;    // bits held in the collector (0..2)
  logic             col_mode_r;   // mode latched with the first bit

  logic [KW-1:0]    k_r;          // sample index inside the carrier period
  logic [PW-1:0]    per_r;        // carrier period inside the symbol
  logic [KW-1:0]    phase_r;      // phase applied to the active symbol

  logic [WIDTH-1:0] sample_r;
  logic             sample_valid_r;
  logic             sym_start_r;
  logic             underrun_r;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic             full_s;
  logic             accept_s;
  logic             boundary_s;
  logic             xfer_s;
  logic             under_s;
  logic [KW-1:0]    off_s;
  logic [KW-1:0]    new_phase_s;
  logic [KW-1:0]    idx_s;
  logic [1:0]       quad_s;
  logic [KW-3:0]    pos_s;
  logic [KW-2:0]    qidx_s;
  logic [WIDTH-2:0] qval_s;
  logic [WIDTH-1:0] lut_s;

  // Collector status and input handshake
  always_comb begin
    full_s = 1'b0;
    if (col_cnt_r == 2'd2) begin
      full_s = 1'b1;
    end else if ((col_cnt_r == 2'd1) && !col_mode_r) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    bit_ready = en && !full_s && !rst;
    accept_s  = bit_valid && bit_ready;
  end

  // Phase offset of the symbol waiting in the collector (QPSK is Gray coded)
  always_comb begin
    off_s = {KW{1'b0}};
    if (!col_mode_r) begin
      if (col_r[0]) begin
        off_s = OFF_Q2;
      end else begin
        off_s = {KW{1'b0}};
      end
    end else begin
      case (col_r)
        2'b00:   off_s = {KW{1'b0}};
        2'b01:   off_s = OFF_Q1;
        2'b11:   off_s = OFF_Q2;
        2'b10:   off_s = OFF_Q3;
        default: off_s = {KW{1'b0}};
      endcase
    end
  end

  // Phase to apply when the waiting symbol is transferred
  always_comb begin
    new_phase_s = {KW{1'b0}};
`ifdef PSK_DIFF_EN
    // Running sum wraps naturally at LUT_SIZE because KW bits are kept.
    new_phase_s = phase_r + off_s;
`else
    new_phase_s = off_s;
`endif
  end

  // Sine lookup: unfold the quarter-wave table by quadrant symmetry
  always_comb begin
    idx_s  = k_r + phase_r;
    quad_s = idx_s[KW-1:KW-2];
    pos_s  = idx_s[KW-3:0];
    qidx_s = {1'b0, pos_s};
    if (quad_s[0]) begin
      // falling quarter: mirror around the peak
      qidx_s = QN_IDX - {1'b0, pos_s};
    end else begin
      qidx_s = {1'b0, pos_s};
    end
    qval_s = qtab_s[qidx_s];
    if (quad_s[1]) begin
      lut_s = MID - {1'b0, qval_s};
    end else begin
      lut_s = MID + {1'b0, qval_s};
    end
  end

  // FSM next-state logic and symbol transfer decision
  always_comb begin
    state_nx_s = state_r;
    xfer_s     = 1'b0;
    under_s    = 1'b0;
    boundary_s = (k_r == K_LAST) && (per_r == P_LAST);
    case (state_r)
      ST_IDLE: begin
        if (full_s) begin
          xfer_s     = 1'b1;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (boundary_s) begin
          if (full_s) begin
            // seamless hand-over to the next symbol
            xfer_s     = 1'b1;
            state_nx_s = ST_RUN;
          end else begin
            under_s    = 1'b1;
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else if (en) begin
      state_r <= state_nx_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Bit collector: shift in accepted bits, empty on transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r      <= 2'b00;
      col_cnt_r  <= 2'd0;
      col_mode_r <= 1'b0;
    end else if (en) begin
      if (xfer_s) begin
        col_r     <= 2'b00;
        col_cnt_r <= 2'd0;
      end else if (accept_s) begin
        col_r     <= {col_r[0], bit_in};
        col_cnt_r <= col_cnt_r + 2'd1;
        if (col_cnt_r == 2'd0) begin
          col_mode_r <= mode;
        end else begin
          col_mode_r <= col_mode_r;
        end
      end else begin
        col_r     <= col_r;
        col_cnt_r <= col_cnt_r;
      end
    end else begin
      col_r      <= col_r;
      col_cnt_r  <= col_cnt_r;
      col_mode_r <= col_mode_r;
    end
  end

  // Sample / period counters and active-symbol phase
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r     <= {KW{1'b0}};
      per_r   <= {PW{1'b0}};
      phase_r <= {KW{1'b0}};
    end else if (en) begin
      if (xfer_s) begin
        k_r     <= {KW{1'b0}};
        per_r   <= {PW{1'b0}};
        phase_r <= new_phase_s;
      end else if (state_r == ST_RUN) begin
        if (k_r == K_LAST) begin
          k_r <= {KW{1'b0}};
          if (per_r == P_LAST) begin
            per_r <= {PW{1'b0}};
          end else begin
            per_r <= per_r + PW'(1);
          end
        end else begin
          k_r <= k_r + KW'(1);
        end
        // an underrun ends the phase history
        if (under_s) begin
          phase_r <= {KW{1'b0}};
        end else begin
          phase_r <= phase_r;
        end
      end else begin
        k_r     <= k_r;
        per_r   <= per_r;
        phase_r <= phase_r;
      end
    end else begin
      k_r     <= k_r;
      per_r   <= per_r;
      phase_r <= phase_r;
    end
  end

  // Registered outputs: one sample per enabled cycle while running
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_r       <= MID;
      sample_valid_r <= 1'b0;
      sym_start_r    <= 1'b0;
      underrun_r     <= 1'b0;
    end else if (en) begin
      if (state_r == ST_RUN) begin
        sample_r       <= lut_s;
        sample_valid_r <= 1'b1;
        sym_start_r    <= (k_r == {KW{1'b0}}) && (per_r == {PW{1'b0}});
        underrun_r     <= under_s;
      end else begin
        sample_r       <= MID;
        sample_valid_r <= 1'b0;
        sym_start_r    <= 1'b0;
        underrun_r     <= 1'b0;
      end
    end else begin
      sample_r       <= sample_r;
      sample_valid_r <= sample_valid_r;
      sym_start_r    <= sym_start_r;
      underrun_r     <= underrun_r;
    end
  end

  assign sample_out   = sample_r;
  assign sample_valid = sample_valid_r;
  assign sym_start    = sym_start_r;
  assign underrun     = underrun_r;

endmodule

// File: tb/tb_psk_mod.sv
`timescale 1ns/1ps
module tb_psk_mod;

  localparam int  W       = 8;
  localparam int  N       = 64;
  localparam int  C       = 2;
  localparam int  SYM_LEN = N * C;
  localparam real PI      = 3.14159265358979323846;

  logic         clk = 1'b0;
  logic         rst, en, mode, bit_in, bit_valid;
  logic         bit_ready, sample_valid, sym_start, underrun;
  logic [W-1:0] sample_out;

  psk_mod #(.WIDTH(W), .LUT_SIZE(N), .CYCLES_PER_SYM(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sym_start    (sym_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic m; logic b0; logic b1; } sym_t;

  int   tests_run    = 0;
  int   tests_failed = 0;

  sym_t syms[$];
  int   exp_phase[$];
  int   cap_samp[$];
  bit   cap_valid[$], cap_ss[$], cap_ur[$], cap_en[$], cap_rdy[$];
  int   f_samp[$];
  bit   f_valid[$];
  int   ss_pos[$], ur_pos[$], acc_pos[$];
  int   stall_at  = -1;
  int   stall_len = 0;
  int   vprob     = 100;
  bit   timed_out;

  // ---------------- reference model ----------------
  function automatic int sine_ref(input int i);
    real v;
    v = ((1 << (W - 1)) - 1) * $sin(2.0 * PI * (i % N) / N);
    if (v >= 0.0) return (1 << (W - 1)) + $rtoi(v + 0.5);
    return (1 << (W - 1)) - $rtoi(-v + 0.5);
  endfunction

  // BPSK: bit selects 0 or half a period. QPSK: Gray dibit -> quadrant number.
  function automatic int sym_off(input sym_t s);
    int quadrant;
    if (!s.m) return s.b0 ? N / 2 : 0;
    quadrant = (s.b0 ? 2 : 0) + ((s.b0 ^ s.b1) ? 1 : 0);
    return quadrant * (N / 4);
  endfunction

  task automatic build_model();
    int acc = 0;
    exp_phase.delete();
    foreach (syms[s]) begin
`ifdef PSK_DIFF_EN
      acc = (acc + sym_off(syms[s])) % N;
`else
      acc = sym_off(syms[s]);
`endif
      exp_phase.push_back(acc);
    end
  endtask

  function automatic int fs(input int i);
    if (i >= 0 && i < f_samp.size()) return f_samp[i];
    return -1;
  endfunction

  function automatic int fv(input int i);
    if (i >= 0 && i < f_valid.size()) return int'(f_valid[i]);
    return -1;
  endfunction

  // number of samples of one symbol that differ from the model
  function automatic int sym_errs(input int start, input int phase);
    int e = 0;
    for (int j = 0; j < SYM_LEN; j++) begin
      if (fv(start + j) != 1 || fs(start + j) != sine_ref((j % N) + phase)) e++;
    end
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b1; en = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; mode = 1'b0;
    stall_at = -1; stall_len = 0; vprob = 100;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Feed syms as a bit stream and record outputs every cycle until the
  // final underrun (+2 cycles) or the budget runs out.
  task automatic run(input int budget);
    bit bq[$];
    bit mq[$];
    bit en_prev;
    int tail;
    int n;
    cap_samp.delete(); cap_valid.delete(); cap_ss.delete(); cap_ur.delete();
    cap_en.delete(); cap_rdy.delete(); acc_pos.delete();
    foreach (syms[s]) begin
      bq.push_back(syms[s].b0); mq.push_back(syms[s].m);
      if (syms[s].m) begin bq.push_back(syms[s].b1); mq.push_back(1'b1); end
    end
    en_prev = en; tail = -1; n = 0; timed_out = 1'b1;
    while (n < budget) begin
      @(negedge clk);
      cap_samp.push_back(int'(sample_out));
      cap_valid.push_back(sample_valid);
      cap_ss.push_back(sym_start);
      cap_ur.push_back(underrun);
      cap_en.push_back(en_prev);
      if (tail > 0) tail--;
      else if (tail < 0 && underrun === 1'b1 && en_prev && bq.size() == 0) tail = 2;
      en = (stall_at >= 0 && n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
      if (bq.size() > 0 && int'($urandom_range(99)) < vprob) begin
        bit_valid = 1'b1; bit_in = bq[0]; mode = mq[0];
      end else begin
        bit_valid = 1'b0;
      end
      #1;
      cap_rdy.push_back(bit_ready);
      if (bit_valid && bit_ready) begin
        void'(bq.pop_front()); void'(mq.pop_front()); acc_pos.push_back(n);
      end
      en_prev = en;
      n++;
      if (tail == 0) begin timed_out = 1'b0; break; end
    end
    bit_valid = 1'b0;
  endtask

  // keep only observations that follow an enabled edge
  task automatic filter_capture();
    f_samp.delete(); f_valid.delete(); ss_pos.delete(); ur_pos.delete();
    foreach (cap_samp[i]) begin
      if (cap_en[i]) begin
        f_samp.push_back(cap_samp[i]);
        f_valid.push_back(cap_valid[i]);
        if (cap_ss[i]) ss_pos.push_back(f_samp.size() - 1);
        if (cap_ur[i]) ur_pos.push_back(f_samp.size() - 1);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; mode = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (sample_out !== 8'd128) begin tests_failed++; $display("FAIL reset_sample got %0d want 128", sample_out); end
      tests_run++;
      if (sample_valid !== 1'b0 || sym_start !== 1'b0 || underrun !== 1'b0) begin
        tests_failed++; $display("FAIL reset_flags got v=%b s=%b u=%b want 0 0 0", sample_valid, sym_start, underrun);
      end
      tests_run++;
      if (bit_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got %b want 0", bit_ready); end
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (bit_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_reset got %b want 1", bit_ready); end
  endtask

  task automatic test_bpsk_single();
    int exp4[4];
    int base, nvalid, exp_ur;
    exp4 = '{128, 255, 128, 1};
    do_reset();
    syms.delete(); syms.push_back('{m: 1'b0, b0: 1'b0, b1: 1'b0});
    build_model(); run(400); filter_capture();
    tests_run++;
    if (timed_out !== 1'b0) begin tests_failed++; $display("FAIL bpsk1_timeout got no underrun within budget"); end
    tests_run++;
    if (ss_pos.size() != 1) begin tests_failed++; $display("FAIL bpsk1_sym_starts got %0d want 1", ss_pos.size()); end
    base = (ss_pos.size() > 0) ? ss_pos[0] : 0;
    tests_run++;
    if (acc_pos.size() < 1 || base != acc_pos[0] + 3) begin
      tests_failed++; $display("FAIL bpsk1_latency got first sample at %0d want accept+3", base);
    end
    for (int q = 0; q < 4; q++) begin
      tests_run++;
      if (fs(base + 16 * q) != exp4[q]) begin
        tests_failed++; $display("FAIL bpsk1_k%0d got %0d want %0d", 16 * q, fs(base + 16 * q), exp4[q]);
      end
    end
    tests_run++;
    if (sym_errs(base, exp_phase[0]) != 0) begin
      tests_failed++; $display("FAIL bpsk1_samples got %0d wrong samples want 0", sym_errs(base, exp_phase[0]));
    end
    nvalid = 0;
    foreach (f_valid[i]) if (f_valid[i]) nvalid++;
    tests_run++;
    if (nvalid != SYM_LEN) begin tests_failed++; $display("FAIL bpsk1_length got %0d want %0d", nvalid, SYM_LEN); end
    exp_ur = base + SYM_LEN - 1;
    tests_run++;
    if (ur_pos.size() != 1 || ur_pos[0] != exp_ur) begin
      tests_failed++; $display("FAIL bpsk1_underrun got %0d pulses want 1 at %0d", ur_pos.size(), exp_ur);
    end
    tests_run++;
    if (fv(exp_ur + 1) != 0 || fs(exp_ur + 1) != 128) begin
      tests_failed++; $display("FAIL bpsk1_idle got v=%0d s=%0d want v=0 s=128", fv(exp_ur + 1), fs(exp_ur + 1));
    end
  endtask

  // covers "bits 1,0" (and "1,1" which exercises the differential phase)
  task automatic test_back_to_back(input logic second_bit);
    int s0, s1, gaps;
    do_reset();
    syms.delete();
    syms.push_back('{m: 1'b0, b0: 1'b1, b1: 1'b0});
    syms.push_back('{m: 1'b0, b0: second_bit, b1: 1'b0});
    build_model(); run(600); filter_capture();
    tests_run++;
    if (timed_out !== 1'b0 || ss_pos.size() != 2) begin
      tests_failed++; $display("FAIL b2b%0b_starts got %0d sym_start want 2", second_bit, ss_pos.size());
    end
    s0 = (ss_pos.size() > 0) ? ss_pos[0] : 0;
    s1 = (ss_pos.size() > 1) ? ss_pos[1] : 0;
    tests_run++;
    if (s1 - s0 != SYM_LEN) begin tests_failed++; $display("FAIL b2b%0b_spacing got %0d want %0d", second_bit, s1 - s0, SYM_LEN); end
    tests_run++;
    if (fs(s0 + 16) != sine_ref(16 + exp_phase[0])) begin
      tests_failed++; $display("FAIL b2b%0b_sym0_k16 got %0d want %0d", second_bit, fs(s0 + 16), sine_ref(16 + exp_phase[0]));
    end
    tests_run++;
    if (fs(s1 + 16) != sine_ref(16 + exp_phase[1])) begin
      tests_failed++; $display("FAIL b2b%0b_sym1_k16 got %0d want %0d", second_bit, fs(s1 + 16), sine_ref(16 + exp_phase[1]));
    end
    gaps = 0;
    for (int i = s0; i < s0 + 2 * SYM_LEN; i++) if (fv(i) != 1) gaps++;
    tests_run++;
    if (gaps != 0) begin tests_failed++; $display("FAIL b2b%0b_gapless got %0d idle cycles want 0", second_bit, gaps); end
    tests_run++;
    if (ur_pos.size() != 1 || ur_pos[0] != s1 + SYM_LEN - 1) begin
      tests_failed++; $display("FAIL b2b%0b_underrun got %0d pulses want 1 at end", second_bit, ur_pos.size());
    end
  endtask

  task automatic test_qpsk();
    do_reset();
    syms.delete();
    syms.push_back('{m: 1'b1, b0: 1'b0, b1: 1'b1});
    syms.push_back('{m: 1'b1, b0: 1'b1, b1: 1'b0});
    build_model(); run(600); filter_capture();
    tests_run++;
    if (timed_out !== 1'b0 || ss_pos.size() != 2) begin
      tests_failed++; $display("FAIL qpsk_starts got %0d sym_start want 2", ss_pos.size());
    end
    for (int s = 0; s < 2; s++) begin
      int st;
      st = (ss_pos.size() > s) ? ss_pos[s] : 0;
      tests_run++;
      if (fs(st) != sine_ref(exp_phase[s])) begin
        tests_failed++; $display("FAIL qpsk_sym%0d_k0 got %0d want %0d", s, fs(st), sine_ref(exp_phase[s]));
      end
      tests_run++;
      if (sym_errs(st, exp_phase[s]) != 0) begin
        tests_failed++; $display("FAIL qpsk_sym%0d_samples got %0d wrong want 0", s, sym_errs(st, exp_phase[s]));
      end
    end
  endtask

  task automatic test_stall();
    int ss_raw, ur_raw, held, rdy_bad;
    do_reset();
    syms.delete(); syms.push_back('{m: 1'b0, b0: 1'b0, b1: 1'b0});
    stall_at = 40; stall_len = 5;
    build_model(); run(400); filter_capture();
    ss_raw = -1; ur_raw = -1;
    foreach (cap_ss[i]) begin
      if (cap_ss[i] && ss_raw < 0) ss_raw = i;
      if (cap_ur[i] && ur_raw < 0) ur_raw = i;
    end
    held = 0; rdy_bad = 0;
    for (int i = stall_at + 1; i <= stall_at + stall_len; i++)
      if (i >= cap_samp.size() || cap_samp[i] != cap_samp[stall_at]) held++;
    for (int i = stall_at; i < stall_at + stall_len; i++)
      if (i >= cap_rdy.size() || cap_rdy[i] !== 1'b0) rdy_bad++;
    tests_run++;
    if (held != 0) begin tests_failed++; $display("FAIL stall_hold got %0d changed samples want 0", held); end
    tests_run++;
    if (rdy_bad != 0) begin tests_failed++; $display("FAIL stall_ready got %0d cycles ready want 0", rdy_bad); end
    tests_run++;
    if (timed_out !== 1'b0 || ss_raw < 0 || ur_raw - ss_raw != SYM_LEN - 1 + stall_len) begin
      tests_failed++; $display("FAIL stall_length got %0d want %0d", ur_raw - ss_raw + 1, SYM_LEN + stall_len);
    end
    tests_run++;
    if (ss_pos.size() != 1 || sym_errs((ss_pos.size() > 0) ? ss_pos[0] : 0, exp_phase[0]) != 0) begin
      tests_failed++; $display("FAIL stall_samples got %0d starts or wrong samples want clean symbol", ss_pos.size());
    end
  endtask

  task automatic test_random(input int round);
    int nsym, exp_ur;
    do_reset();
    nsym = int'($urandom_range(3, 6));
    vprob = int'($urandom_range(30, 100));
    syms.delete();
    for (int s = 0; s < nsym; s++)
      syms.push_back('{m: 1'($urandom_range(1)), b0: 1'($urandom_range(1)), b1: 1'($urandom_range(1))});
    build_model(); run(nsym * SYM_LEN + 200); filter_capture();
    tests_run++;
    if (timed_out !== 1'b0 || ss_pos.size() != nsym) begin
      tests_failed++; $display("FAIL rand%0d_starts got %0d want %0d", round, ss_pos.size(), nsym);
    end
    for (int s = 0; s < nsym; s++) begin
      int e;
      if (s < ss_pos.size()) begin
        e = sym_errs(ss_pos[s], exp_phase[s]);
        if (s + 1 < ss_pos.size() && ss_pos[s + 1] - ss_pos[s] != SYM_LEN) e++;
      end else begin
        e = SYM_LEN;
      end
      tests_run++;
      if (e != 0) begin tests_failed++; $display("FAIL rand%0d_sym%0d got %0d errors want 0 (phase %0d)", round, s, e, exp_phase[s]); end
    end
    exp_ur = (ss_pos.size() > 0) ? ss_pos[ss_pos.size() - 1] + SYM_LEN - 1 : -1;
    tests_run++;
    if (ur_pos.size() != 1 || ur_pos[0] != exp_ur) begin
      tests_failed++; $display("FAIL rand%0d_underrun got %0d pulses want 1 at %0d", round, ur_pos.size(), exp_ur);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    syms.delete(); syms.push_back('{m: 1'b0, b0: 1'b1, b1: 1'b0});
    run(60);
    rst = 1'b1; en = 1'b0; bit_valid = 1'b0;
    #1;
    tests_run++;
    if (bit_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ready got %b want 0", bit_ready); end
    @(negedge clk);
    tests_run++;
    if (sample_out !== 8'd128 || sample_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_output got s=%0d v=%b want 128 0", sample_out, sample_valid);
    end
    rst = 1'b0; en = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (sample_valid !== 1'b0 || bit_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_idle got v=%b r=%b want 0 1", sample_valid, bit_ready);
    end
  endtask

  initial begin
    test_reset();
    test_bpsk_single();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_qpsk();
    test_stall();
    for (int r = 0; r < 3; r++) test_random(r);
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
